// File: rtl/spi_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder_if
// Purpose : bundles the SPI-bridge byte stream and the register-file access
//           signals used by spi_cmd_decoder.
// Signals : byte_sync/data_in/data_out  - SPI slave bridge side
//           reg_addr/reg_hi/reg_wdata/reg_we/reg_re/reg_rdata - register file
//           timeout_err - frame aborted by inter-byte timeout
// Modports: slave  - the decoder (consumes bytes, drives register accesses)
//           master - the environment (bridge + register file)
// ---------------------------------------------------------------------------
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 6
);
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_hi;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              timeout_err;

  modport slave (
    input  byte_sync, data_in, reg_rdata,
    output data_out, reg_addr, reg_hi, reg_wdata, reg_we, reg_re, timeout_err
  );

  modport master (
    output byte_sync, data_in, reg_rdata,
    input  data_out, reg_addr, reg_hi, reg_wdata, reg_we, reg_re, timeout_err
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
// Purpose : turns 2-byte SPI frames (command, data) from the SPI slave bridge
//           into register-file write/read accesses. Read data is returned on
//           data_out so the bridge shifts it out during the next frame.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           bus    - spi_cmd_decoder_if.slave (bridge bytes + register access)
// Command : bit7 = 1 write / 0 read, bit6 = hi/lo byte, bits[ADDR_W-1:0] = addr
// ---------------------------------------------------------------------------
module spi_cmd_decoder #(
  parameter int ADDR_W      = 6,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_cmd_decoder_if.slave    bus
);

  localparam logic [0:0] ST_CMD  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  // Terminal count of the inter-byte timer; only meaningful when enabled.
  localparam logic          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [0:0]        r_state;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hi;
  logic [7:0]        r_wdata;
  logic              r_we;
  logic              r_re;
  logic              r_re_d;
  logic [7:0]        r_dout;
  logic              r_to_err;
  logic [TO_W-1:0]   r_cnt;

  logic              w_expire;

  // Timeout fires only when no byte arrives in the expiry cycle (byte wins).
  always_comb begin
    w_expire = 1'b0;
    if (TO_EN && (r_state == ST_DATA) && !bus.byte_sync && (r_cnt == TO_LAST)) begin
      w_expire = 1'b1;
    end else begin
      w_expire = 1'b0;
    end
  end

  // Frame FSM, register-access strobes, timeout counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_CMD;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_hi     <= 1'b0;
      r_wdata  <= 8'h00;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_re_d   <= 1'b0;
      r_dout   <= 8'h00;
      r_to_err <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_to_err <= 1'b0;
      // Register file answers one clk after reg_re; grab its data then.
      r_re_d   <= r_re;
      if (r_re_d) begin
        r_dout <= bus.reg_rdata;
      end

      case (r_state)
        ST_CMD: begin
          if (bus.byte_sync) begin
            r_addr  <= bus.data_in[ADDR_W-1:0];
            r_hi    <= bus.data_in[6];
            r_rw    <= bus.data_in[7];
            // Reads are issued right away so data is ready for the next frame.
            r_re    <= ~bus.data_in[7];
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.byte_sync) begin
            // Second byte of a read frame is a dummy and is dropped.
            if (r_rw) begin
              r_wdata <= bus.data_in;
              r_we    <= 1'b1;
            end
            r_state <= ST_CMD;
          end else if (w_expire) begin
            r_to_err <= 1'b1;
            r_state  <= ST_CMD;
          end else if (r_cnt != {TO_W{1'b1}}) begin
            // Saturate rather than wrap so a disabled timer never re-triggers.
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_CMD;
        end
      endcase
    end
  end

  assign bus.data_out    = r_dout;
  assign bus.reg_addr    = r_addr;
  assign bus.reg_hi      = r_hi;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_we      = r_we;
  assign bus.reg_re      = r_re;
  assign bus.timeout_err = r_to_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_decoder
// Purpose : directed self-checking bench for spi_cmd_decoder (TIMEOUT_CYC=8).
//           Drives bytes at negedges, samples outputs at negedges, and models
//           a register file with a one-clk read latency.
// ---------------------------------------------------------------------------
module tb_spi_cmd_decoder;

  logic clk;
  logic rst_n;

  spi_cmd_decoder_if #(.ADDR_W(6)) bus ();

  spi_cmd_decoder #(
    .ADDR_W      (6),
    .TO_W        (16),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the DUT, indexed by {hi, addr}.
  logic [7:0] mem [0:127];
  // Expected register contents, maintained from the bench's own intent.
  logic [7:0] exp_mem [0:127];

  always @(posedge clk) begin
    if (bus.reg_we) mem[{bus.reg_hi, bus.reg_addr}] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[{bus.reg_hi, bus.reg_addr}];
  end

  int total  = 0;
  int passed = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;
  int exp_we = 0;
  int exp_re = 0;

  // Pulse monitor: strobes are one clk wide so a negedge sample counts each once.
  always @(negedge clk) begin
    if (bus.reg_we) we_cnt++;
    if (bus.reg_re) re_cnt++;
    if (bus.timeout_err) to_cnt++;
    if (bus.reg_we && bus.reg_re) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Called at a negedge; byte is sampled on the next posedge (cycle N),
  // task returns at the negedge of cycle N+1.
  task automatic send(input logic [7:0] b);
    bus.byte_sync = 1'b1;
    bus.data_in   = b;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] cmd, dat;
  logic       rw, hi;
  logic [5:0] addr;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    mem[7]     = 8'h99;
    exp_mem[7] = 8'h99;
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    bus.reg_rdata = 8'h00;
    rst_n = 1'b0;
    idle(3);

    // Reset state
    check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
    check("rst_addr",     {26'd0, bus.reg_addr}, 32'h00);
    check("rst_strobes",  {29'd0, bus.reg_we, bus.reg_re, bus.timeout_err}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1. Write 0xC5, 0x3A -> addr 5, hi 1, wdata 0x3A
    send(8'hC5);
    check("t1_cmd_no_we", {31'd0, bus.reg_we}, 32'h0);
    check("t1_cmd_no_re", {31'd0, bus.reg_re}, 32'h0);
    check("t1_addr", {26'd0, bus.reg_addr}, 32'h05);
    check("t1_hi",   {31'd0, bus.reg_hi},   32'h1);
    idle(3);
    send(8'h3A);
    check("t1_we",    {31'd0, bus.reg_we},    32'h1);
    check("t1_wdata", {24'd0, bus.reg_wdata}, 32'h3A);
    exp_we++; exp_mem[{1'b1, 6'd5}] = 8'h3A;
    idle(1);
    check("t1_we_1clk", {31'd0, bus.reg_we}, 32'h0);
    idle(2);

    // 2. Read 0x07 with register holding 0x99, then dummy 0x00
    send(8'h07);
    check("t2_re",   {31'd0, bus.reg_re},   32'h1);
    check("t2_addr", {26'd0, bus.reg_addr}, 32'h07);
    check("t2_hi",   {31'd0, bus.reg_hi},   32'h0);
    exp_re++;
    idle(1);
    check("t2_re_1clk", {31'd0, bus.reg_re}, 32'h0);
    idle(1);
    check("t2_data_out", {24'd0, bus.data_out}, 32'h99);
    send(8'h00);
    check("t2_dummy_no_we", {31'd0, bus.reg_we}, 32'h0);
    idle(2);

    // 3. Timeout: 0x81 then idle; pulse expected in the 9th cycle after byte
    send(8'h81);
    idle(7);
    check("t3_no_early_to", {31'd0, bus.timeout_err}, 32'h0);
    idle(1);
    check("t3_timeout", {31'd0, bus.timeout_err}, 32'h1);
    idle(1);
    check("t3_to_1clk", {31'd0, bus.timeout_err}, 32'h0);
    idle(1);
    send(8'h82);
    idle(3);
    send(8'h11);
    check("t3_we",    {31'd0, bus.reg_we},    32'h1);
    check("t3_addr",  {26'd0, bus.reg_addr},  32'h02);
    check("t3_wdata", {24'd0, bus.reg_wdata}, 32'h11);
    exp_we++; exp_mem[{1'b0, 6'd2}] = 8'h11;
    check("t3_dout_held", {24'd0, bus.data_out}, 32'h99);
    idle(2);

    // 4. Data byte lands in the exact expiry cycle -> write, no timeout
    send(8'h83);
    idle(7);
    send(8'h4D);
    check("t4_we",    {31'd0, bus.reg_we},      32'h1);
    check("t4_no_to", {31'd0, bus.timeout_err}, 32'h0);
    check("t4_wdata", {24'd0, bus.reg_wdata},   32'h4D);
    exp_we++; exp_mem[{1'b0, 6'd3}] = 8'h4D;
    idle(1);
    check("t4_no_to_late", {31'd0, bus.timeout_err}, 32'h0);
    idle(2);

    // 5. Reset after command byte discards the frame
    send(8'h83);
    rst_n = 1'b0;
    #1;
    check("t5_rst_addr",  {26'd0, bus.reg_addr}, 32'h00);
    check("t5_rst_dout",  {24'd0, bus.data_out}, 32'h00);
    check("t5_rst_wdata", {24'd0, bus.reg_wdata}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send(8'h84);
    check("t5_cmd_no_we", {31'd0, bus.reg_we}, 32'h0);
    idle(3);
    send(8'h55);
    check("t5_we",    {31'd0, bus.reg_we},    32'h1);
    check("t5_addr",  {26'd0, bus.reg_addr},  32'h04);
    check("t5_wdata", {24'd0, bus.reg_wdata}, 32'h55);
    exp_we++; exp_mem[{1'b0, 6'd4}] = 8'h55;
    idle(2);

    // 6. Random back-to-back frames against the expected register image
    for (int k = 0; k < 10; k++) begin
      rw   = 1'($urandom_range(0, 1));
      hi   = 1'($urandom_range(0, 1));
      addr = 6'($urandom_range(0, 63));
      dat  = 8'($urandom_range(0, 255));
      cmd  = {rw, hi, addr};
      send(cmd);
      check("t6_addr", {26'd0, bus.reg_addr}, {26'd0, addr});
      check("t6_re",   {31'd0, bus.reg_re},   {31'd0, ~rw});
      if (rw) begin
        idle(3);
        send(dat);
        check("t6_wdata", {24'd0, bus.reg_wdata}, {24'd0, dat});
        exp_we++; exp_mem[{hi, addr}] = dat;
      end else begin
        exp_re++;
        idle(2);
        check("t6_rdata", {24'd0, bus.data_out}, {24'd0, exp_mem[{hi, addr}]});
        send(8'h00);
      end
      idle(2);
    end

    check("we_pulses",  we_cnt, exp_we);
    check("re_pulses",  re_cnt, exp_re);
    check("to_pulses",  to_cnt, 1);
    check("we_re_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
